// File: rtl/dir_key_conditioner_pkg.sv
// Shared constants for the direction key conditioner: direction indices,
// arbitration priority order and the per-key press/repeat FSM encoding.
package dir_key_pkg;

  localparam int unsigned NUM_DIRS = 4;

  localparam int unsigned DIR_U = 0;
  localparam int unsigned DIR_R = 1;
  localparam int unsigned DIR_D = 2;
  localparam int unsigned DIR_L = 3;

  // Highest priority first.
  localparam int unsigned PRIO_ORDER [NUM_DIRS] = '{DIR_U, DIR_R, DIR_D, DIR_L};

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_DELAY  = 2'd1,
    ST_REPEAT = 2'd2
  } key_state_e;

  // One-hot grant for the highest-priority requesting direction.
  function automatic logic [NUM_DIRS-1:0] first_pending(input logic [NUM_DIRS-1:0] req);
    logic found;
    first_pending = '0;
    found         = 1'b0;
    for (int i = 0; i < NUM_DIRS; i++) begin
      if (!found && req[PRIO_ORDER[i]]) begin
        first_pending[PRIO_ORDER[i]] = 1'b1;
        found                        = 1'b1;
      end
    end
  endfunction

endpackage

// File: rtl/dir_key_conditioner_if.sv
// Button-side and event-side signals of the direction key conditioner.
// Events are fire-and-forget: U/R/D/L are one-cycle pulses with no ready/backpressure.
interface dir_key_conditioner_if;
  logic       up;
  logic       right;
  logic       down;
  logic       left;
  logic       U;
  logic       R;
  logic       D;
  logic       L;
  logic [3:0] held;
  logic [7:0] fsm_state;  // 2 bits per key, {L,D,R,U}

  modport master (output up, right, down, left,
                  input  U, R, D, L, held, fsm_state);
  modport slave  (input  up, right, down, left,
                  output U, R, D, L, held, fsm_state);
endinterface

// File: rtl/dir_key_conditioner_key_debounce.sv
// Per-key 2-FF synchroniser and debounce counter; emits the debounced level
// and a one-cycle strobe on each accepted rising level change.
module key_debounce #(
  parameter int unsigned DEBOUNCE_CYCLES = 1_000_000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic raw_i,
  output logic level_o,
  output logic rise_o
);
  localparam int unsigned CW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic          sync1_q, sync2_q;
  logic          level_q, rise_q;
  logic [CW-1:0] cnt_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      level_q <= 1'b0;
      rise_q  <= 1'b0;
      cnt_q   <= '0;
    end else begin
      sync1_q <= raw_i;
      sync2_q <= sync1_q;
      rise_q  <= 1'b0;
      if (sync2_q == level_q) begin
        cnt_q <= '0;
      end else if (cnt_q >= CNT_LAST) begin
        // Sample has disagreed for DEBOUNCE_CYCLES consecutive cycles.
        level_q <= sync2_q;
        rise_q  <= sync2_q;
        cnt_q   <= '0;
      end else begin
        cnt_q <= cnt_q + 1'b1;
      end
    end
  end

  assign level_o = level_q;
  assign rise_o  = rise_q;
endmodule

// File: rtl/dir_key_conditioner.sv
// Direction key conditioner: debounce, press/auto-repeat FSMs, pending bits and
// a U>R>D>L arbiter. Auto-repeat is built only with DIR_KEY_AUTOREPEAT_EN defined.
module dir_key_conditioner
  import dir_key_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = 1_000_000,
  parameter int unsigned REPEAT_DELAY    = 40_000_000,
  parameter int unsigned REPEAT_PERIOD   = 10_000_000
) (
  input logic                  clk,
  input logic                  clr,
  dir_key_conditioner_if.slave keys
);
  logic [NUM_DIRS-1:0]   raw, level, rise, set_pend;
  logic [NUM_DIRS-1:0]   pend_q, pend_d, pulse_q, held_q, grant;
  logic [2*NUM_DIRS-1:0] state_flat;

  if (DEBOUNCE_CYCLES < 2 || REPEAT_DELAY < 2 || REPEAT_PERIOD < 2) begin : g_bad_cfg
    $error("dir_key_conditioner: cycle parameters must be at least 2");
  end

`ifdef DIR_KEY_AUTOREPEAT_EN
  localparam int unsigned RMAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
  localparam int unsigned RW   = (RMAX > 1) ? $clog2(RMAX) : 1;
  localparam logic [RW-1:0] RD_LAST = RW'(REPEAT_DELAY - 1);
  localparam logic [RW-1:0] RP_LAST = RW'(REPEAT_PERIOD - 1);
`endif

  assign raw[DIR_U] = keys.up;
  assign raw[DIR_R] = keys.right;
  assign raw[DIR_D] = keys.down;
  assign raw[DIR_L] = keys.left;

  for (genvar i = 0; i < NUM_DIRS; i++) begin : g_key
    key_state_e state_q;

    key_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_debounce (
      .clk     (clk),
      .rst_n   (clr),
      .raw_i   (raw[i]),
      .level_o (level[i]),
      .rise_o  (rise[i])
    );

`ifdef DIR_KEY_AUTOREPEAT_EN
    logic [RW-1:0] rcnt_q;
    logic          delay_done, period_done;

    assign delay_done  = (rcnt_q == RD_LAST);
    assign period_done = (rcnt_q == RP_LAST);

    // A debounced fall wins over a same-cycle repeat tick.
    assign set_pend[i] = ((state_q == ST_IDLE) && rise[i]) ||
                         (level[i] && (((state_q == ST_DELAY)  && delay_done) ||
                                       ((state_q == ST_REPEAT) && period_done)));

    always_ff @(posedge clk or negedge clr) begin
      if (!clr) begin
        state_q <= ST_IDLE;
        rcnt_q  <= '0;
      end else if ((state_q != ST_IDLE) && !level[i]) begin
        state_q <= ST_IDLE;
        rcnt_q  <= '0;
      end else begin
        case (state_q)
          ST_IDLE: begin
            if (rise[i]) state_q <= ST_DELAY;
            rcnt_q <= '0;
          end
          ST_DELAY: begin
            if (delay_done) begin
              state_q <= ST_REPEAT;
              rcnt_q  <= '0;
            end else if (rcnt_q != '1) begin
              rcnt_q <= rcnt_q + 1'b1;
            end
          end
          ST_REPEAT: begin
            if (period_done)        rcnt_q <= '0;
            else if (rcnt_q != '1)  rcnt_q <= rcnt_q + 1'b1;
          end
          default: begin
            state_q <= ST_IDLE;
            rcnt_q  <= '0;
          end
        endcase
      end
    end
`else
    // Press-edge only: DELAY just marks "held since the last press event".
    assign set_pend[i] = (state_q == ST_IDLE) && rise[i];

    always_ff @(posedge clk or negedge clr) begin
      if (!clr)                                 state_q <= ST_IDLE;
      else if ((state_q != ST_IDLE) && !level[i]) state_q <= ST_IDLE;
      else if ((state_q == ST_IDLE) && rise[i])   state_q <= ST_DELAY;
    end
`endif

    assign state_flat[2*i +: 2] = state_q;
  end

  // Set wins over drain so a same-cycle re-trigger produces a second pulse.
  assign grant  = first_pending(pend_q);
  assign pend_d = (pend_q & ~grant) | set_pend;

  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      pend_q  <= '0;
      pulse_q <= '0;
      held_q  <= '0;
    end else begin
      pend_q  <= pend_d;
      pulse_q <= grant;
      held_q  <= level;
    end
  end

  assign keys.U         = pulse_q[DIR_U];
  assign keys.R         = pulse_q[DIR_R];
  assign keys.D         = pulse_q[DIR_D];
  assign keys.L         = pulse_q[DIR_L];
  assign keys.held      = held_q;
  assign keys.fsm_state = state_flat;
endmodule
